// File: rtl/l2_snack_if.sv
// rtl/l2_snack_if.sv - L1/L2 miss request, snoop-ack and displacement signal bundle
interface l2_snack_if;
  logic       l1tol2_req_valid;
  logic       l1tol2_req_retry;
  logic [2:0] l1tol2_req;
  logic       l2tol1_snack_valid;
  logic [4:0] l2tol1_snack;
  logic       l1tol2_disp_valid;
  logic [2:0] l1tol2_disp;

  modport master (
    output l1tol2_req_valid, l1tol2_req, l1tol2_disp_valid, l1tol2_disp,
    input  l1tol2_req_retry, l2tol1_snack_valid, l2tol1_snack
  );

  modport slave (
    input  l1tol2_req_valid, l1tol2_req, l1tol2_disp_valid, l1tol2_disp,
    output l1tol2_req_retry, l2tol1_snack_valid, l2tol1_snack
  );
endinterface

// File: rtl/l2_snack_responder.sv
// rtl/l2_snack_responder.sv - L2 responder: queues L1 miss requests, returns one snack each after LATENCY
// Optional macro L2_SNACK_UPGRADE_EN: grant ACK_M to a REQ_S when no other queued REQ_S is waiting.
module l2_snack_responder #(
  parameter int DEPTH      = 4,
  parameter int LATENCY    = 3,
  parameter int DISP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  l2_snack_if.slave             bus,
  output logic                  busy,
  output logic [DISP_CNT_W-1:0] disp_count,
  output logic                  err_sticky
);
  localparam logic [2:0] SC_CMD_REQ_S  = 3'b001;
  localparam logic [2:0] SC_CMD_REQ_M  = 3'b010;
  localparam logic [4:0] SC_SCMD_ACK_S = 5'h11;
  localparam logic [4:0] SC_SCMD_ACK_M = 5'h12;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      mem_q [DEPTH];
  logic [2:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            snack_valid_q, snack_valid_d;
  logic [4:0]      snack_q, snack_d;
  logic            err_q, err_d;
  logic [DISP_CNT_W-1:0] disp_q, disp_d;

  logic            full, push, pop, head_known, sole_s;
  logic [2:0]      head;
  logic [4:0]      head_ack;
  logic            unused_disp;

  assign unused_disp          = ^bus.l1tol2_disp;
  assign full                 = (count_q == CW'(DEPTH));
  assign bus.l1tol2_req_retry = full | reset;
  assign push                 = bus.l1tol2_req_valid & ~bus.l1tol2_req_retry;
  assign pop                  = (state_q == RESP);
  assign head                 = mem_q[rd_ptr_q];

`ifdef L2_SNACK_UPGRADE_EN
  // The head itself is excluded: only later queued REQ_S entries block the upgrade.
  always_comb begin
    sole_s = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (mem_q[rd_ptr_q + AW'(i)] == SC_CMD_REQ_S)) begin
        sole_s = 1'b0;
      end
    end
  end
`else
  assign sole_s = 1'b0;
`endif

  always_comb begin
    head_known = 1'b1;
    head_ack   = 5'd0;
    case (head)
      SC_CMD_REQ_S: head_ack = sole_s ? SC_SCMD_ACK_M : SC_SCMD_ACK_S;
      SC_CMD_REQ_M: head_ack = SC_SCMD_ACK_M;
      default:      head_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          if (LATENCY > 1) begin
            wcnt_d  = WW'(LATENCY - 1);
            state_d = WAIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - WW'(1);
        if (wcnt_q == WW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Snack is registered on entry to RESP so the pulse coincides with the RESP cycle.
    snack_valid_d = (state_d == RESP) && (state_q != RESP) && head_known;
    snack_d       = snack_valid_d ? head_ack : 5'd0;
    err_d         = err_q | (pop & ~head_known);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.l1tol2_req;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    disp_d = disp_q;
    if (bus.l1tol2_disp_valid && (disp_q != '1)) disp_d = disp_q + DISP_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wcnt_q        <= '0;
      snack_valid_q <= 1'b0;
      snack_q       <= 5'd0;
      err_q         <= 1'b0;
      disp_q        <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wcnt_q        <= wcnt_d;
      snack_valid_q <= snack_valid_d;
      snack_q       <= snack_d;
      err_q         <= err_d;
      disp_q        <= disp_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.l2tol1_snack_valid = snack_valid_q;
  assign bus.l2tol1_snack       = snack_q;
  assign busy                   = (count_q != '0) || (state_q != IDLE);
  assign disp_count             = disp_q;
  assign err_sticky             = err_q;
endmodule

// File: tb/tb_l2_snack_responder.sv
// tb/tb_l2_snack_responder.sv - randomized self-checking bench for l2_snack_responder
module tb_l2_snack_responder;
  localparam int DEPTH      = 4;
  localparam int LATENCY    = 3;
  localparam int DISP_CNT_W = 8;
  localparam logic [2:0] REQ_S   = 3'b001;
  localparam logic [2:0] REQ_M   = 3'b010;
  localparam logic [2:0] REQ_BAD = 3'b111;
  localparam logic [4:0] ACK_S   = 5'h11;
  localparam logic [4:0] ACK_M   = 5'h12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, err_sticky;
  logic [DISP_CNT_W-1:0] disp_count;

  l2_snack_if bus();

  l2_snack_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .DISP_CNT_W(DISP_CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .disp_count(disp_count), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Reference: each accepted request is answered at max(prev_ack + L+1, drive_cycle + L+1).
  typedef struct {logic [2:0] cmd; int t; int r;} ent_t;
  ent_t mq[$];
  int   cyc, last_r, m_disp, checks, errors;
  bit   m_err;
  logic e_retry, e_sv, e_busy, e_err;
  logic [4:0] e_snack;
  logic [DISP_CNT_W-1:0] e_disp;

  function automatic bit known(input logic [2:0] c);
    return (c == REQ_S) || (c == REQ_M);
  endfunction

  function automatic logic [4:0] head_ack();
    if (mq[0].cmd == REQ_M) return ACK_M;
`ifdef L2_SNACK_UPGRADE_EN
    for (int i = 1; i < mq.size(); i++)
      if (mq[i].cmd == REQ_S && mq[i].t <= mq[0].r - 2) return ACK_S;
    return ACK_M;
`else
    return ACK_S;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_err  = 1'b0;
    m_disp = 0;
    last_r = -100;
  endtask

  task automatic cyc_run(input logic v, input logic [2:0] code, input logic d);
    int r;
    @(posedge clk); #1;
    reset                 = 1'b0;
    bus.l1tol2_req_valid  = v;
    bus.l1tol2_req        = code;
    bus.l1tol2_disp_valid = d;
    bus.l1tol2_disp       = 3'($urandom);
    cyc++;
    while (mq.size() > 0 && mq[0].r < cyc) begin
      if (!known(mq[0].cmd)) m_err = 1'b1;
      void'(mq.pop_front());
    end
    e_retry = (mq.size() == DEPTH);
    e_sv    = (mq.size() > 0) && (mq[0].r == cyc) && known(mq[0].cmd);
    e_snack = e_sv ? head_ack() : 5'd0;
    e_busy  = (mq.size() != 0);
    e_err   = m_err;
    e_disp  = DISP_CNT_W'(m_disp);
    if (v && !e_retry) begin
      r = (last_r + LATENCY + 1 > cyc + LATENCY + 1) ? last_r + LATENCY + 1 : cyc + LATENCY + 1;
      mq.push_back('{cmd: code, t: cyc, r: r});
      last_r = r;
    end
    if (d && m_disp < (1 << DISP_CNT_W) - 1) m_disp++;
    @(negedge clk);
  endtask

  task automatic test_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset                 = 1'b1;
      bus.l1tol2_req_valid  = 1'($urandom);
      bus.l1tol2_disp_valid = 1'b1;
      cyc++;
      @(negedge clk);
      checks++;
      if (bus.l1tol2_req_retry !== 1'b1) begin
        errors++;
        $display("FAIL reset_retry cyc %0d: got %b expected 1", cyc, bus.l1tol2_req_retry);
      end
    end
    model_reset();
    cyc_run(1'b0, REQ_S, 1'b0);
    checks++;
    if ({bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: retry/sv/snack/busy/err/disp got %b/%b/%h/%b/%b/%0d expected all 0",
               bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count);
    end
  endtask

  task automatic test_single();
    int t0, hit, nhit;
    logic [4:0] val;
    hit = -1; nhit = 0; val = 5'd0;
    t0 = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      cyc_run(i == 0, REQ_S, 1'b0);
      checks++;
      if ({bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count} !==
          {e_retry, e_sv, e_snack, e_busy, e_err, e_disp}) begin
        errors++;
        $display("FAIL single cyc %0d: retry/sv/snack/busy/err/disp got %b/%b/%h/%b/%b/%0d expected %b/%b/%h/%b/%b/%0d",
                 cyc, bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count,
                 e_retry, e_sv, e_snack, e_busy, e_err, e_disp);
      end
      if (bus.l2tol1_snack_valid) begin hit = cyc; val = bus.l2tol1_snack; nhit++; end
      if (cyc == t0 + LATENCY + 2) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_low: got %b expected 0", busy); end
      end
    end
    checks++;
    if (nhit != 1 || hit != t0 + LATENCY + 1 || val !== ACK_S) begin
      errors++;
      $display("FAIL single_latency: got %0d pulses at offset %0d value %h, expected 1 at %0d value %h",
               nhit, hit - t0, val, LATENCY + 1, ACK_S);
    end
  endtask

  task automatic test_back_to_back();
    int t0, acks[$];
    logic [4:0] vals[$];
    t0 = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      cyc_run(i < 6, REQ_M, 1'b0);
      checks++;
      if ({bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count} !==
          {e_retry, e_sv, e_snack, e_busy, e_err, e_disp}) begin
        errors++;
        $display("FAIL b2b cyc %0d: retry/sv/snack/busy/err/disp got %b/%b/%h/%b/%b/%0d expected %b/%b/%h/%b/%b/%0d",
                 cyc, bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count,
                 e_retry, e_sv, e_snack, e_busy, e_err, e_disp);
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (bus.l1tol2_req_retry !== (i == 4)) begin
          errors++;
          $display("FAIL full_pop_retry attempt %0d: got %b expected %b", i + 1, bus.l1tol2_req_retry, i == 4);
        end
      end
      if (bus.l2tol1_snack_valid) begin acks.push_back(cyc - t0); vals.push_back(bus.l2tol1_snack); end
    end
    checks++;
    if (acks.size() != 5) begin
      errors++;
      $display("FAIL b2b_ack_count: got %0d expected 5", acks.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (acks[k] != (k + 1) * (LATENCY + 1) || vals[k] !== ACK_M) begin
          errors++;
          $display("FAIL b2b_ack%0d: got offset %0d value %h expected offset %0d value %h",
                   k, acks[k], vals[k], (k + 1) * (LATENCY + 1), ACK_M);
        end
      end
    end
  endtask

  task automatic test_unknown();
    int n;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      cyc_run(i < 2, (i == 0) ? REQ_BAD : REQ_S, 1'b0);
      checks++;
      if ({bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count} !==
          {e_retry, e_sv, e_snack, e_busy, e_err, e_disp}) begin
        errors++;
        $display("FAIL unknown cyc %0d: retry/sv/snack/busy/err/disp got %b/%b/%h/%b/%b/%0d expected %b/%b/%h/%b/%b/%0d",
                 cyc, bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count,
                 e_retry, e_sv, e_snack, e_busy, e_err, e_disp);
      end
      if (bus.l2tol1_snack_valid) n++;
    end
    checks++;
    if (n != 1 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL unknown_code: got %0d pulses err %b expected 1 pulse err 1", n, err_sticky);
    end
  endtask

  task automatic test_disp_saturate();
    for (int i = 0; i < 300; i++) begin
      cyc_run($urandom_range(0, 3) == 0, $urandom_range(0, 1) ? REQ_S : REQ_M, 1'b1);
      checks++;
      if ({bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count} !==
          {e_retry, e_sv, e_snack, e_busy, e_err, e_disp}) begin
        errors++;
        $display("FAIL disp cyc %0d: retry/sv/snack/busy/err/disp got %b/%b/%h/%b/%b/%0d expected %b/%b/%h/%b/%b/%0d",
                 cyc, bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count,
                 e_retry, e_sv, e_snack, e_busy, e_err, e_disp);
      end
    end
    checks++;
    if (disp_count !== 8'd255) begin
      errors++;
      $display("FAIL disp_saturate: got %0d expected 255", disp_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    cyc_run(1'b1, REQ_S, 1'b0);
    cyc_run(1'b1, REQ_M, 1'b0);
    cyc_run(1'b0, REQ_S, 1'b0);
    test_reset(2);
    for (int i = 0; i < 12; i++) begin
      cyc_run(1'b0, REQ_S, 1'b0);
      if (bus.l2tol1_snack_valid) n++;
      checks++;
      if (busy !== 1'b0 || bus.l1tol2_req_retry !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: busy/retry got %b/%b expected 0/0", cyc, busy, bus.l1tol2_req_retry);
      end
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL reset_mid_snack: got %0d pulses expected 0", n);
    end
  endtask

  task automatic test_random();
    logic [2:0] code;
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel  = $urandom_range(0, 9);
      code = (sel < 4) ? REQ_S : (sel < 8) ? REQ_M : 3'($urandom);
      cyc_run(1'($urandom), code, 1'($urandom));
      checks++;
      if ({bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count} !==
          {e_retry, e_sv, e_snack, e_busy, e_err, e_disp}) begin
        errors++;
        $display("FAIL random cyc %0d: retry/sv/snack/busy/err/disp got %b/%b/%h/%b/%b/%0d expected %b/%b/%h/%b/%b/%0d",
                 cyc, bus.l1tol2_req_retry, bus.l2tol1_snack_valid, bus.l2tol1_snack, busy, err_sticky, disp_count,
                 e_retry, e_sv, e_snack, e_busy, e_err, e_disp);
      end
    end
  endtask

  initial begin
    bus.l1tol2_req_valid  = 1'b0;
    bus.l1tol2_req        = 3'd0;
    bus.l1tol2_disp_valid = 1'b0;
    bus.l1tol2_disp       = 3'd0;
    cyc = 0; checks = 0; errors = 0;
    model_reset();
    test_reset(3);
    test_single();
    test_back_to_back();
    test_unknown();
    test_reset(2);
    test_disp_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_snack_responder.md
Name: l2_snack_responder

Overview:
- L2-side responder for the L1 data cache miss interface.
- Accepts 3-bit L1→L2 miss requests (`SC_CMD_REQ_S` / `SC_CMD_REQ_M` from scmemc.vh) on a valid/retry handshake and queues them in order.
- Returns one 5-bit snoop-ack (`SC_SCMD_ACK_S` / `SC_SCMD_ACK_M`) per request on l2tol1_snack after a fixed service latency.
- Sinks L1 displacement commands. Serves as the far-end model and bring-up responder for the DC tag-check/miss path.

Parameters:
- DEPTH, 4, request queue entries; power of two, ≥2.
- LATENCY, 3, wait cycles between head-of-queue service start and snack issue; ≥1.
- DISP_CNT_W, 8, width of the displacement counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- l1tol2_req_valid  in  1  request valid
- l1tol2_req_retry  out  1  request not accepted this cycle
- l1tol2_req  in  3  request command
- l2tol1_snack_valid  out  1  ack valid, one-cycle pulse; no backpressure
- l2tol1_snack  out  5  ack command
- l1tol2_disp_valid  in  1  displacement valid; always accepted
- l1tol2_disp  in  3  displacement command
- busy  out  1  queue non-empty or FSM not IDLE
- disp_count  out  DISP_CNT_W  saturating count of accepted displacements
- err_sticky  out  1  unknown request code seen

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Outputs under reset: all outputs 0 except l1tol2_req_retry. Queue emptied; FSM to IDLE; counters cleared.
- Retry during reset: l1tol2_req_retry = 1 while reset is high.
- Reset mid-operation: in-flight and queued requests are discarded; no snack is issued for them.
- Acceptance: a request is accepted when l1tol2_req_valid && !l1tol2_req_retry.
  - l1tol2_req_retry = full. It is combinational from the registered count.
  - There is no pass-through. When full, retry stays high even in the cycle a pop occurs.
- Queue: in-order FIFO holding the 3-bit command. Count register is clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: the count is unchanged.
- FSM states and transitions:
  - IDLE: if queue non-empty, load wait counter = LATENCY-1 and go to WAIT.
  - WAIT: decrement the wait counter; at 0 go to RESP.
  - RESP: drive l2tol1_snack_valid = 1 and l2tol1_snack = ack(head). Pop the head. Go to IDLE.
- Head entry: the head is not removed until RESP.
- Ack mapping: `SC_CMD_REQ_S` → `SC_SCMD_ACK_S`; `SC_CMD_REQ_M` → `SC_SCMD_ACK_M`.
- Unknown request code: no snack is issued (snack_valid stays 0 in RESP). The entry is still popped and err_sticky is set. err_sticky clears only on reset.
- Latency: a request accepted at cycle T into an empty queue with FSM in IDLE produces snack at T+LATENCY+1.
  - Back-to-back requests are spaced LATENCY+1 cycles apart, so throughput is one ack per LATENCY+1 cycles.
- snack_valid: registered, high for exactly one cycle per ack. l2tol1_snack is held at 0 when snack_valid is 0.
- Displacement: every cycle with l1tol2_disp_valid = 1 increments disp_count, saturating at all-ones. The displacement command value is ignored. Displacement is independent of the request path and may coincide with any state.
- busy = (count != 0) || (state != IDLE).

Optional Feature:
- Macro: L2_SNACK_UPGRADE_EN.
- Defined: `SC_CMD_REQ_S` is answered with `SC_SCMD_ACK_M` whenever no other queued entry (excluding the head) is a REQ_S, i.e. sole sharer granted exclusive. `SC_CMD_REQ_M` mapping is unchanged.
- Undefined: the straight S→S, M→M mapping is used.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset, then a single `SC_CMD_REQ_S` at cycle 10 with LATENCY=3 → snack_valid pulse at cycle 14 with `SC_SCMD_ACK_S`; busy low at cycle 15.
- 4 back-to-back REQ_M with DEPTH=4 → retry high on the 5th attempt. Acks at T+4, T+8, T+12, T+16, all `SC_SCMD_ACK_M`, in order.
- Queue full while a pop occurs in RESP → retry remains 1 that cycle; the request is accepted the next cycle; count is correct.
- Request code 3'b111 → no snack pulse, err_sticky=1; a following REQ_S is still acked normally.
- 300 cycles of continuous l1tol2_disp_valid → disp_count=255 (saturated); request path unaffected.
- Reset asserted during WAIT with 2 queued → no snack afterwards; busy=0; retry=1 during reset and 0 after.
